// File: rtl/data_dewhiting_if.sv
// Byte stream into and out of the receive-side de-whitener.
// The master drives din/din_valid/indicator; the slave returns the decoded stream.
interface data_dewhiting_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       din;
  logic             din_valid;
  logic             indicator;
  logic [7:0]       dout;
  logic             dout_valid;
  logic             payload;
  logic             frame_last;
  logic             next_indicator;
  logic [CNT_W-1:0] payload_count;

  modport master (
    output din, din_valid, indicator,
    input  dout, dout_valid, payload, frame_last, next_indicator, payload_count
  );

  modport slave (
    input  din, din_valid, indicator,
    output dout, dout_valid, payload, frame_last, next_indicator, payload_count
  );
endinterface

// File: rtl/data_dewhiting.sv
// Receive-side de-whitening: follows start/pad/payload framing and XORs the
// 9-bit LFSR keystream out of payload bytes, one registered output per accepted byte.
module data_dewhiting #(
  parameter int PAD_BYTES = 80,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  data_dewhiting_if.slave  bus
);
  localparam int PW = (PAD_BYTES > 1) ? $clog2(PAD_BYTES) : 1;

  typedef enum logic [1:0] {
    WAITING  = 2'd0,
    PADDING  = 2'd1,
    ENCODING = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] pad_cnt;
  logic [8:0]    lfsr;
  logic [7:0]    key;
  logic [2:0]    idx;
  logic [8:0]    lfsr_nxt;

  assign lfsr_nxt = {lfsr[5] ^ lfsr[0], lfsr[8:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= WAITING;
      pad_cnt            <= '0;
      lfsr               <= 9'h1FF;
      key                <= 8'hFF;
      idx                <= '0;
      bus.dout           <= '0;
      bus.dout_valid     <= 1'b0;
      bus.payload        <= 1'b0;
      bus.frame_last     <= 1'b0;
      bus.next_indicator <= 1'b0;
      bus.payload_count  <= '0;
    end else begin
      // Flags are single-cycle; dout only changes on accepted bytes.
      bus.dout_valid     <= bus.din_valid;
      bus.next_indicator <= bus.din_valid & bus.indicator;
      bus.payload        <= 1'b0;
      bus.frame_last     <= 1'b0;
      if (bus.din_valid) begin
        bus.dout <= bus.din;
        case (state)
          WAITING: begin
            lfsr    <= 9'h1FF;
            key     <= 8'hFF;
            pad_cnt <= '0;
            idx     <= '0;
            if (bus.indicator) begin
              state             <= PADDING;
              bus.payload_count <= '0;
            end
          end
          PADDING: begin
            if (pad_cnt == PW'(PAD_BYTES - 1)) begin
              state   <= ENCODING;
              pad_cnt <= '0;
              lfsr    <= lfsr_nxt;
            end else begin
              pad_cnt <= pad_cnt + 1'b1;
            end
          end
          ENCODING: begin
            bus.dout    <= bus.din ^ key;
            bus.payload <= 1'b1;
            if (bus.payload_count != '1)
              bus.payload_count <= bus.payload_count + 1'b1;
            lfsr <= lfsr_nxt;
            idx  <= idx + 3'd1;
            // Key refresh uses the state before this byte's advance.
            if (idx == 3'd7)
              key <= lfsr[7:0];
            if (bus.indicator) begin
              bus.frame_last <= 1'b1;
              state          <= WAITING;
              lfsr           <= 9'h1FF;
              key            <= 8'hFF;
              idx            <= '0;
            end
          end
          default: begin
            state   <= WAITING;
            pad_cnt <= '0;
            lfsr    <= 9'h1FF;
            key     <= 8'hFF;
            idx     <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_dewhiting.sv
// Randomized bench for data_dewhiting against a byte-position reference model.
module tb_data_dewhiting;
  localparam int PAD   = 80;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  data_dewhiting_if #(.CNT_W(CNT_W)) ifc ();

  data_dewhiting #(.PAD_BYTES(PAD), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model: position of each accepted byte relative to the last start indicator
  bit         m_in_frame;
  int         m_pos;
  int         m_cnt;
  logic [7:0] exp_dout;
  logic       exp_valid, exp_pay, exp_last, exp_nind;
  int         exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // PN9 keystream byte for payload index i: refreshed every 8 bytes, 8 shifts per block.
  function automatic logic [7:0] pn9_key(input int i);
    logic [8:0] s;
    s = 9'h1FF;
    for (int k = 0; k < 8 * (i / 8); k++) s = {s[5] ^ s[0], s[8:1]};
    return s[7:0];
  endfunction

  function automatic void model_clear();
    m_in_frame = 0; m_pos = 0; m_cnt = 0;
    exp_dout = 8'h00; exp_valid = 0; exp_pay = 0; exp_last = 0; exp_nind = 0; exp_cnt = 0;
  endfunction

  function automatic void model_accept(input logic v, input logic [7:0] d, input logic ind);
    exp_valid = v; exp_pay = 0; exp_last = 0; exp_nind = v & ind;
    if (v) begin
      exp_dout = d;
      if (!m_in_frame) begin
        if (ind) begin m_in_frame = 1; m_pos = 0; m_cnt = 0; end
      end else begin
        m_pos++;
        if (m_pos > PAD) begin
          exp_dout = d ^ pn9_key(m_pos - PAD - 1);
          exp_pay  = 1;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          if (ind) begin exp_last = 1; m_in_frame = 0; end
        end
      end
    end
    exp_cnt = m_cnt;
  endfunction

  task automatic check_outputs();
    chk("dout_valid", ifc.dout_valid, exp_valid);
    chk("dout", ifc.dout, exp_dout);
    chk("payload", ifc.payload, exp_pay);
    chk("frame_last", ifc.frame_last, exp_last);
    chk("next_indicator", ifc.next_indicator, exp_nind);
    chk("payload_count", ifc.payload_count, exp_cnt);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic ind);
    @(negedge clk);
    check_outputs();
    ifc.din = d; ifc.din_valid = v; ifc.indicator = ind;
    model_accept(v, d, ind);
  endtask

  // mode 0: back-to-back, 1: gap after every byte, 2: random gaps
  task automatic send_byte(input logic [7:0] d, input logic ind, input int mode);
    if (mode == 2)
      while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'($urandom));
    step(1'b1, d, ind);
    if (mode == 1) step(1'b0, 8'($urandom), 1'($urandom));
  endtask

  task automatic send_pads(input int n, input int mode, input bit rnd);
    for (int i = 0; i < n; i++)
      send_byte(rnd ? 8'($urandom) : 8'(i), rnd ? 1'($urandom_range(0, 3) == 0) : 1'b0, mode);
  endtask

  task automatic send_payload(input logic [7:0] w[$], input int mode);
    for (int i = 0; i < w.size(); i++) send_byte(w[i], 1'(i == w.size() - 1), mode);
  endtask

  task automatic send_frame(input logic [7:0] w[$], input int mode, input bit rnd);
    send_byte(8'hA5, 1'b1, mode);
    send_pads(PAD, mode, rnd);
    send_payload(w, mode);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    check_outputs();
    ifc.din_valid = 1'b0; ifc.indicator = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst dout", ifc.dout, 0);
    chk("rst dout_valid", ifc.dout_valid, 0);
    chk("rst payload", ifc.payload, 0);
    chk("rst frame_last", ifc.frame_last, 0);
    chk("rst next_indicator", ifc.next_indicator, 0);
    chk("rst payload_count", ifc.payload_count, 0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic void make_known(output logic [7:0] w[$], input int n);
    w = {};
    for (int i = 0; i < n; i++) w.push_back(i < 8 ? 8'hFF : 8'hE1);
  endfunction

  function automatic void make_random(output logic [7:0] w[$], input int n);
    w = {};
    for (int i = 0; i < n; i++) w.push_back(8'($urandom) ^ pn9_key(i));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w[$];
    reset_n = 1'b0;
    ifc.din = 8'h00; ifc.din_valid = 1'b0; ifc.indicator = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // known keystream frame: start, 80 counting pads, 8xFF + 8xE1
    make_known(w, 16);
    send_frame(w, 0, 0);
    step(1'b1, 8'h3C, 1'b0);

    // same frame with a gap after every byte
    send_frame(w, 1, 0);
    step(1'b1, 8'h5A, 1'b0);

    // back-to-back frames, random pads with stray indicators
    send_frame(w, 0, 1);
    send_frame(w, 0, 1);

    // single-byte payload
    make_known(w, 1);
    send_frame(w, 2, 1);

    // reset in the padding, then junk until a fresh frame
    send_byte(8'hA5, 1'b1, 0);
    send_pads(40, 0, 1);
    pulse_reset();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 2);
    make_known(w, 16);
    send_frame(w, 0, 1);

    // reset after five payload bytes
    send_byte(8'hA5, 1'b1, 0);
    send_pads(PAD, 0, 1);
    for (int i = 0; i < 5; i++) send_byte(8'hFF, 1'b0, 0);
    pulse_reset();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 2);
    send_frame(w, 0, 1);

    // loopback of random payloads whitened by the bench keystream
    for (int f = 0; f < 3; f++) begin
      make_random(w, 200);
      send_frame(w, 2, 1);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 2);
    end

    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
